// File: rtl/h14tx_rst_seq_pkg.sv
// Shared types and default sizing for the TX reset sequencer.
package h14tx_rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_WAIT_LOCK,
    ST_RELEASE,
    ST_RUN,
    ST_TEARDOWN
  } state_t;

  localparam int DEF_NUM_STAGES     = 4;
  localparam int DEF_GUARD_CYCLES   = 16;
  localparam int DEF_TIMEOUT_CYCLES = 65536;
  localparam int DEF_PLL_RST_CYCLES = 32;

endpackage

// File: rtl/h14tx_guard_timer.sv
// Saturating cycle timer: done is high while the count sits at COUNT-1.
// clr has priority over en; the count never wraps past the terminal value.
module h14tx_guard_timer
  import h14tx_rst_seq_pkg::*;
#(
  parameter int COUNT = DEF_GUARD_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int W = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [W-1:0] LAST = W'(COUNT - 1);

  logic [W-1:0] count;

  // count up while enabled, stop at the terminal value
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && !done) begin
      count <= count + 1'b1;
    end
  end

  assign done = (count == LAST);

endmodule

// File: rtl/h14tx_rst_seq.sv
// TX pipeline reset sequencer: waits for stable PLL lock, releases the
// downstream reset domains lowest index first, tears them down highest first.
// Optional lock-wait watchdog is built when H14TX_RST_SEQ_WATCHDOG_EN is defined.
//
//  state        | meaning
//  -------------+-----------------------------------------------------------
//  ST_HOLD      | all domains in reset, waiting for req_rst to drop
//  ST_WAIT_LOCK | counting consecutive lock-high cycles (plus watchdog)
//  ST_RELEASE   | releasing one domain every GUARD_CYCLES, idx = last released
//  ST_RUN       | all domains out of reset, ready high
//  ST_TEARDOWN  | re-asserting one domain per cycle from idx down to 0
module h14tx_rst_seq
  import h14tx_rst_seq_pkg::*;
#(
  parameter int NUM_STAGES     = DEF_NUM_STAGES,
  parameter int GUARD_CYCLES   = DEF_GUARD_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lock,
  input  logic                  req_rst,
  output logic [NUM_STAGES-1:0] stage_rst,
  output logic                  ready,
  output logic                  pll_rst,
  output logic                  timeout_err
);

  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

  if (NUM_STAGES < 2 || GUARD_CYCLES < 2 || TIMEOUT_CYCLES < 2 || PLL_RST_CYCLES < 1)
  begin : g_bad_cfg
    $error("h14tx_rst_seq: parameter out of range");
  end

  state_t                state, state_nxt;
  logic [IDX_W-1:0]      idx, idx_nxt;
  logic [NUM_STAGES-1:0] stage_nxt;
  logic                  ready_nxt;
  logic                  guard_clr, guard_en, guard_done;
  logic                  abort;
  logic                  wd_busy;

  assign abort = !lock || req_rst;

  h14tx_guard_timer #(.COUNT(GUARD_CYCLES)) u_guard (
    .clk  (clk),
    .rst  (rst),
    .clr  (guard_clr),
    .en   (guard_en),
    .done (guard_done)
  );

  // state, index and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_HOLD;
      idx       <= '0;
      stage_rst <= '1;
      ready     <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      stage_rst <= stage_nxt;
      ready     <= ready_nxt;
    end
  end

  // next-state logic; guard timer is cleared unless explicitly counting
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    stage_nxt = stage_rst;
    ready_nxt = ready;
    guard_clr = 1'b1;
    guard_en  = 1'b0;
    unique case (state)
      ST_HOLD: begin
        stage_nxt = '1;
        ready_nxt = 1'b0;
        idx_nxt   = '0;
        if (!req_rst) state_nxt = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (req_rst) begin
          state_nxt = ST_HOLD;
        end else if (wd_busy) begin
          // PLL is being reset; lock history is meaningless, keep guard at 0
          state_nxt = ST_WAIT_LOCK;
        end else if (lock && guard_done) begin
          state_nxt    = ST_RELEASE;
          stage_nxt[0] = 1'b0;
          idx_nxt      = '0;
        end else if (lock) begin
          guard_clr = 1'b0;
          guard_en  = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (abort) begin
          state_nxt = ST_TEARDOWN;
        end else if (guard_done) begin
          if (idx != LAST_IDX) begin
            idx_nxt                  = idx + 1'b1;
            stage_nxt[idx + 1'b1]    = 1'b0;
          end else begin
            state_nxt = ST_RUN;
            ready_nxt = 1'b1;
          end
        end else begin
          guard_clr = 1'b0;
          guard_en  = 1'b1;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_nxt = ST_TEARDOWN;
          ready_nxt = 1'b0;
        end
      end
      ST_TEARDOWN: begin
        ready_nxt      = 1'b0;
        stage_nxt[idx] = 1'b1;
        if (idx == '0) state_nxt = ST_HOLD;
        else           idx_nxt   = idx - 1'b1;
      end
      default: begin
        state_nxt = ST_HOLD;
      end
    endcase
  end

`ifdef H14TX_RST_SEQ_WATCHDOG_EN
  logic in_wait;
  logic tmo_done, pulse_done, pulse_active, tmo_err;
  logic fire;

  assign in_wait = (state == ST_WAIT_LOCK);
  // timeout only fires if the FSM is staying in WaitLock this cycle
  assign fire    = in_wait && tmo_done && !pulse_active && (state_nxt == ST_WAIT_LOCK);

  h14tx_guard_timer #(.COUNT(TIMEOUT_CYCLES)) u_timeout (
    .clk  (clk),
    .rst  (rst),
    .clr  (!in_wait || pulse_active || tmo_done),
    .en   (in_wait),
    .done (tmo_done)
  );

  h14tx_guard_timer #(.COUNT(PLL_RST_CYCLES)) u_pll_pulse (
    .clk  (clk),
    .rst  (rst),
    .clr  (!pulse_active || pulse_done),
    .en   (pulse_active),
    .done (pulse_done)
  );

  // PLL reset pulse and sticky timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      pulse_active <= 1'b0;
      tmo_err      <= 1'b0;
    end else if (fire) begin
      pulse_active <= 1'b1;
      tmo_err      <= 1'b1;
    end else if (pulse_active && (pulse_done || state_nxt != ST_WAIT_LOCK)) begin
      pulse_active <= 1'b0;
    end
  end

  assign wd_busy     = pulse_active;
  assign pll_rst     = pulse_active;
  assign timeout_err = tmo_err;
`else
  assign wd_busy     = 1'b0;
  assign pll_rst     = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule
